// File: rtl/sdio_data_nibble_serdes.sv
// Purpose : SDIO DAT[3:0] pin stage; byte <-> nibble conversion on clk_x2 and DAT output-enable control.
// Latency : TX high nibble on pins 1 clk_x2 after the i_phase edge; RX byte on the i_phase edge after its low nibble.
// Backpres: none; the phy supplies/consumes one byte per phy clk slot.
//
// Ports:
//   clk_x2, rst       nibble clock (2x phy clk), synchronous active-high reset
//   i_phase           high on the clk_x2 cycle that starts a phy byte slot
//   i_en, i_dir       transaction active; 1 = device drives DAT
//   i_byte_out        TX byte, [7:4] sent first
//   o_byte_in         RX byte, updated only on i_phase cycles
//   o_aligned         RX start nibble found, byte alignment locked
//   o_sd_dat_oe/dat   DAT pad output enable / value
//   i_sd_dat          DAT pad input value
module sdio_data_nibble_serdes #(
  parameter int         OE_HOLD  = 1,
  parameter logic [3:0] IDLE_NIB = 4'hF
) (
  input  logic       clk_x2,
  input  logic       rst,
  input  logic       i_phase,
  input  logic       i_en,
  input  logic       i_dir,
  input  logic [7:0] i_byte_out,
  output logic [7:0] o_byte_in,
  output logic       o_aligned,
  output logic       o_sd_dat_oe,
  output logic [3:0] o_sd_dat,
  input  logic [3:0] i_sd_dat
);

  localparam logic [1:0] HOLD_LOAD = 2'(OE_HOLD);

  typedef enum logic [1:0] {TX_OFF, TX_DRIVE, TX_HOLD} tx_state_t;
  typedef enum logic {RX_HUNT, RX_ALIGNED} rx_state_t;

  tx_state_t  tx_state, tx_next;
  logic [1:0] hold_cnt, hold_cnt_next;
  logic [3:0] tx_lo;
  logic       oe_next;
  logic [3:0] dat_next;

  rx_state_t  rx_state, rx_next;
  logic [3:0] rx_nib;
  logic [3:0] hi_reg;
  logic [7:0] pend;
  logic       pend_vld;
  logic       pair;
  logic       tx_busy;
  logic       rx_abort;

  // ---------------- TX FSM ----------------
  always_ff @(posedge clk_x2) begin
    if (rst) begin
      tx_state    <= TX_OFF;
      hold_cnt    <= 2'd0;
      tx_lo       <= IDLE_NIB;
      o_sd_dat_oe <= 1'b0;
      o_sd_dat    <= IDLE_NIB;
    end else begin
      tx_state    <= tx_next;
      hold_cnt    <= hold_cnt_next;
      if (i_phase) tx_lo <= i_byte_out[3:0];
      o_sd_dat_oe <= oe_next;
      o_sd_dat    <= dat_next;
    end
  end

  // Direction is only acted on at byte-slot starts so a nibble pair is never split.
  always_comb begin
    tx_next       = tx_state;
    hold_cnt_next = hold_cnt;
    case (tx_state)
      TX_OFF: begin
        if (i_phase && i_dir) tx_next = TX_DRIVE;
      end
      TX_DRIVE: begin
        if (i_phase && !i_dir) begin
          tx_next       = TX_HOLD;
          hold_cnt_next = HOLD_LOAD;
        end
      end
      TX_HOLD: begin
        if (i_phase && i_dir) begin
          tx_next       = TX_DRIVE;
          hold_cnt_next = 2'd0;
        end else if (hold_cnt <= 2'd1) begin
          // Leaving as the counter reaches zero gives exactly OE_HOLD driven-high cycles.
          tx_next       = TX_OFF;
          hold_cnt_next = 2'd0;
        end else begin
          hold_cnt_next = hold_cnt - 2'd1;
        end
      end
      default: begin
        tx_next       = TX_OFF;
        hold_cnt_next = 2'd0;
      end
    endcase
  end

  // Pad values are registered; computed from the state being entered.
  always_comb begin
    oe_next  = (tx_next != TX_OFF);
    dat_next = IDLE_NIB;
    if (tx_next == TX_DRIVE) dat_next = i_phase ? i_byte_out[7:4] : tx_lo;
  end

  // ---------------- RX FSM ----------------
  assign tx_busy  = (tx_state != TX_OFF);
  assign rx_abort = !i_en || i_dir || tx_busy;

  always_ff @(posedge clk_x2) begin
    if (rst) rx_state <= RX_HUNT;
    else     rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_HUNT:    if (!rx_abort && rx_nib == 4'h0) rx_next = RX_ALIGNED;
      RX_ALIGNED: if (rx_abort) rx_next = RX_HUNT;
      default:    rx_next = RX_HUNT;
    endcase
  end

  assign o_aligned = (rx_state == RX_ALIGNED);

  // RX datapath: pairs nibbles into a pending byte, handed to the phy at slot starts.
  always_ff @(posedge clk_x2) begin
    if (rst) begin
      rx_nib    <= IDLE_NIB;
      hi_reg    <= IDLE_NIB;
      pend      <= 8'hFF;
      pend_vld  <= 1'b0;
      pair      <= 1'b0;
      o_byte_in <= 8'hFF;
    end else begin
      rx_nib <= i_sd_dat;
      if (rx_state == RX_ALIGNED && !rx_abort) begin
        pair <= ~pair;
        if (!pair) hi_reg <= rx_nib;
        if (i_phase && pend_vld) o_byte_in <= pend;
        // A byte completing on a slot edge stays pending; the older one goes out now.
        if (pair) begin
          pend     <= {hi_reg, rx_nib};
          pend_vld <= 1'b1;
        end else if (i_phase) begin
          pend_vld <= 1'b0;
        end
      end else begin
        if (i_phase) o_byte_in <= 8'hFF;
        pend_vld <= 1'b0;
        pair     <= 1'b0;
        // The start nibble occupies the low half of the first byte.
        if (rx_next == RX_ALIGNED) begin
          pend     <= {IDLE_NIB, 4'h0};
          pend_vld <= 1'b1;
        end
      end
    end
  end

endmodule
